// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one shared full adder walks a WIDTH-bit operand pair LSB first,
// then publishes {cout,sum} for one done cycle.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   shift_a;
  logic [WIDTH-1:0]   shift_b;
  logic [WIDTH-1:0]   acc;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               last_bit;
  logic               fa_s;
  logic               fa_co;

  // The single full adder shared by every bit position.
  always_comb begin
    fa_s  = shift_a[0] ^ shift_b[0] ^ carry;
    fa_co = (shift_a[0] & shift_b[0]) | (shift_a[0] & carry) | (shift_b[0] & carry);
  end

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Partial result accumulates in acc so sum stays stable until the final bit lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_a <= '0;
      shift_b <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shift_a <= a;
            shift_b <= b;
            carry   <= cin;
            cnt     <= '0;
          end
        end
        RUN: begin
          carry   <= fa_co;
          acc     <= {fa_s, acc[WIDTH-1:1]};
          shift_a <= shift_a >> 1;
          shift_b <= shift_b >> 1;
          cnt     <= cnt + CNT_W'(1);
          if (last_bit) begin
            sum  <= {fa_s, acc[WIDTH-1:1]};
            cout <= fa_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Checks serial_add_ctrl at WIDTH=8 (directed cases) and WIDTH=4 (all 512 operand sets
// with start held high) against a timeline model of the expected outputs.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;
  bit  armed = 1'b0;
  bit  spacing_on = 1'b0;
  int  last_done4 = -1;
  int  done4_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: ph counts cycles since an accepted start (0 = idle, 1..W busy, W+1 done).
  int         ph8 = 0, ph4 = 0;
  logic [8:0] pend8 = '0, res8 = '0;
  logic [4:0] pend4 = '0, res4 = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      ph8 <= 0; res8 <= '0;
      ph4 <= 0; res4 <= '0;
    end else begin
      if (ph8 == 0) begin
        if (start8) begin ph8 <= 1; pend8 <= {1'b0, a8} + {1'b0, b8} + 9'(cin8); end
      end else if (ph8 <= 8) begin
        ph8 <= ph8 + 1;
        if (ph8 == 8) res8 <= pend8;
      end else ph8 <= 0;

      if (ph4 == 0) begin
        if (start4) begin ph4 <= 1; pend4 <= {1'b0, a4} + {1'b0, b4} + 5'(cin4); end
      end else if (ph4 <= 4) begin
        ph4 <= ph4 + 1;
        if (ph4 == 4) res4 <= pend4;
      end else ph4 <= 0;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("busy8", 32'(busy8), 32'(ph8 >= 1 && ph8 <= 8));
      check("done8", 32'(done8), 32'(ph8 == 9));
      check("sum8",  32'(sum8),  32'(res8[7:0]));
      check("cout8", 32'(cout8), 32'(res8[8]));
      check("busy4", 32'(busy4), 32'(ph4 >= 1 && ph4 <= 4));
      check("done4", 32'(done4), 32'(ph4 == 5));
      check("sum4",  32'(sum4),  32'(res4[3:0]));
      check("cout4", 32'(cout4), 32'(res4[4]));
      if (spacing_on && done4) begin
        done4_cnt++;
        if (last_done4 >= 0) check("done4_spacing", 32'(cyc - last_done4), 32'd6);
        last_done4 = cyc;
      end
    end
  end

  // One WIDTH=8 operation with literal latency/result expectations; operands are
  // scrambled right after capture.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                     input logic [7:0] exp_sum, input logic exp_cout, input string name);
    int nb;
    @(negedge clk);
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    nb = int'(busy8);
    repeat (7) begin @(negedge clk); nb += int'(busy8); end
    check({name, "_busy_cycles"}, 32'(nb), 32'd8);
    @(negedge clk);
    check({name, "_done"}, 32'(done8), 32'd1);
    check({name, "_sum"},  32'(sum8),  32'(exp_sum));
    check({name, "_cout"}, 32'(cout8), 32'(exp_cout));
    @(negedge clk);
    check({name, "_done_end"}, 32'(done8), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nd;
    logic [8:0] vv;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (3) @(negedge clk);
    armed = 1'b1;
    check("reset_busy", 32'(busy8), 32'd0);
    check("reset_done", 32'(done8), 32'd0);
    check("reset_sum",  32'(sum8),  32'd0);
    check("reset_cout", 32'(cout8), 32'd0);
    rst = 1'b0;

    op8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "zero");
    op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ff_plus_1");
    op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "ff_ff_c");
    op8(8'h5A, 8'h25, 1'b1, 8'h80, 1'b0, "5a_25_c");

    // Restart pulse during RUN cycle 3 must be ignored.
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    nd = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done8) nd++;
      if (i == 1) start8 = 1'b0;
      if (i == 3) begin start8 = 1'b1; a8 = 8'hEE; b8 = 8'hEE; cin8 = 1'b1; end
      if (i == 4) start8 = 1'b0;
      if (i == 9) begin
        check("ignore_done", 32'(done8), 32'd1);
        check("ignore_sum",  32'(sum8),  32'h46);
        check("ignore_cout", 32'(cout8), 32'd0);
      end
    end
    check("ignore_done_pulses", 32'(nd), 32'd1);

    // Reset in RUN cycle 4 aborts with no done pulse.
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h44; cin8 = 1'b1; start8 = 1'b1;
    nd = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done8) nd++;
      if (i == 1) start8 = 1'b0;
      if (i == 4) rst = 1'b1;
      if (i == 5) begin
        rst = 1'b0;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        check("abort_sum",  32'(sum8),  32'd0);
        check("abort_cout", 32'(cout8), 32'd0);
      end
    end
    check("abort_done_pulses", 32'(nd), 32'd0);
    op8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, "after_abort");

    // WIDTH=4: every (a,b,cin) with start held high; one accept every 6 cycles.
    @(negedge clk);
    spacing_on = 1'b1;
    for (int v = 0; v < 512; v++) begin
      vv = 9'(v);
      a4 = vv[3:0]; b4 = vv[7:4]; cin4 = vv[8]; start4 = 1'b1;
      repeat (6) @(negedge clk);
    end
    start4 = 1'b0;
    repeat (8) @(negedge clk);
    @(posedge clk);
    check("w4_done_count", 32'(done4_cnt), 32'd512);
    spacing_on = 1'b0;

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
